// File: rtl/fetch_stall_controller.sv
// Fetch-side consumer of the load-use hazard handshake.
// Owns the PC, the IF/ID pipeline register and the ID/EX control register.
// It applies the hold and bubble requests from hazard detection and the
// ID-stage branch flush. It also keeps saturating stall/flush statistics and
// a sticky flag that records inconsistent hold requests.
module fetch_stall_controller #(
  parameter int unsigned          PC_WIDTH    = 32,
  parameter int unsigned          INSTR_WIDTH = 32,
  parameter int unsigned          CTRL_WIDTH  = 9,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
  parameter int unsigned          CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pc_hold,
  input  logic                   ifid_hold,
  input  logic                   stall_or_control,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic [INSTR_WIDTH-1:0] imem_instr,
  input  logic [CTRL_WIDTH-1:0]  id_ctrl_in,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] ifid_instr,
  output logic [PC_WIDTH-1:0]    ifid_pc_plus4,
  output logic                   ifid_valid,
  output logic [CTRL_WIDTH-1:0]  idex_ctrl,
  output logic [CNT_WIDTH-1:0]   stall_count,
  output logic [CNT_WIDTH-1:0]   flush_count,
  output logic                   hold_mismatch
);

  localparam logic [PC_WIDTH-1:0]  PC_STEP = PC_WIDTH'(4);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_WIDTH-1:0]    ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic                   ifid_valid_q, ifid_valid_d;
  logic [CTRL_WIDTH-1:0]  idex_ctrl_q, idex_ctrl_d;
  logic [CNT_WIDTH-1:0]   stall_count_q, stall_count_d;
  logic [CNT_WIDTH-1:0]   flush_count_q, flush_count_d;
  logic                   hold_mismatch_q, hold_mismatch_d;

  logic [PC_WIDTH-1:0]    pc_plus4;
  logic                   do_flush;

  // A branch seen while IF/ID is held has not really resolved yet, so it
  // neither redirects fetch nor flushes; it re-resolves after the stall.
  assign pc_plus4 = pc_q + PC_STEP;
  assign do_flush = branch_taken && !ifid_hold;

  // Next fetch address: hold beats redirect, redirect beats sequential.
  // The redirect target is forced to word alignment.
  always_comb begin
    pc_d = pc_plus4;
    if (pc_hold) begin
      pc_d = pc_q;
    end else if (do_flush) begin
      pc_d = {branch_target[PC_WIDTH-1:2], 2'b00};
    end
  end

  // IF/ID register: hold keeps every field, flush inserts an empty slot, and
  // otherwise the fetched instruction and its PC+4 move into decode.
  always_comb begin
    ifid_instr_d    = imem_instr;
    ifid_pc_plus4_d = pc_plus4;
    ifid_valid_d    = 1'b1;
    if (ifid_hold) begin
      ifid_instr_d    = ifid_instr_q;
      ifid_pc_plus4_d = ifid_pc_plus4_q;
      ifid_valid_d    = ifid_valid_q;
    end else if (branch_taken) begin
      ifid_instr_d    = '0;
      ifid_pc_plus4_d = '0;
      ifid_valid_d    = 1'b0;
    end
  end

  // ID/EX control: a bubble request or an empty decode slot sends zero
  // control; a taken branch in ID still passes its own control along.
  always_comb begin
    idex_ctrl_d = id_ctrl_in;
    if (stall_or_control || !ifid_valid_q) begin
      idex_ctrl_d = '0;
    end
  end

  // Statistics saturate at all-ones. The mismatch flag is sticky until reset.
  always_comb begin
    stall_count_d   = stall_count_q;
    flush_count_d   = flush_count_q;
    hold_mismatch_d = hold_mismatch_q | (pc_hold != ifid_hold);
    if (stall_or_control && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_ONE;
    end
    if (do_flush && (flush_count_q != CNT_MAX)) begin
      flush_count_d = flush_count_q + CNT_ONE;
    end
  end

  // State registers with synchronous reset that overrides every request.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q            <= RESET_PC;
      ifid_instr_q    <= '0;
      ifid_pc_plus4_q <= '0;
      ifid_valid_q    <= 1'b0;
      idex_ctrl_q     <= '0;
      stall_count_q   <= '0;
      flush_count_q   <= '0;
      hold_mismatch_q <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_valid_q    <= ifid_valid_d;
      idex_ctrl_q     <= idex_ctrl_d;
      stall_count_q   <= stall_count_d;
      flush_count_q   <= flush_count_d;
      hold_mismatch_q <= hold_mismatch_d;
    end
  end

  assign pc            = pc_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;
  assign ifid_valid    = ifid_valid_q;
  assign idex_ctrl     = idex_ctrl_q;
  assign stall_count   = stall_count_q;
  assign flush_count   = flush_count_q;
  assign hold_mismatch = hold_mismatch_q;

endmodule

// File: doc/fetch_stall_controller.md
Name: fetch_stall_controller

Overview:
- Consumer end of the load-use hazard handshake.
- Owns the PC register, the IF/ID pipeline register and the ID/EX control register.
- Applies hold requests (PC hold, IF/ID hold) and the bubble request (zero control) raised by hazard detection, plus the ID-stage branch flush.
- Keeps saturating stall/flush statistics and a sticky hold-consistency error flag.

Parameters:
- PC_WIDTH, 32, PC and PC+4 width.
- INSTR_WIDTH, 32, instruction width.
- CTRL_WIDTH, 9, width of the ID control bundle carried into ID/EX.
- RESET_PC, 0, PC value after reset.
- CNT_WIDTH, 16, statistics counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- pc_hold  in  1  1 = hold PC this cycle (hazard unit PCWrite; 1 means hold).
- ifid_hold  in  1  1 = hold IF/ID register this cycle (hazard unit IFIDWrite; 1 means hold).
- stall_or_control  in  1  1 = load zeroes into ID/EX control (bubble).
- branch_taken  in  1  branch resolved taken in ID.
- branch_target  in  PC_WIDTH  taken-branch target.
- imem_instr  in  INSTR_WIDTH  instruction memory data at address pc (combinational fetch).
- id_ctrl_in  in  CTRL_WIDTH  decoded control of the instruction in ID.
- pc  out  PC_WIDTH  current fetch address.
- ifid_instr  out  INSTR_WIDTH  IF/ID instruction.
- ifid_pc_plus4  out  PC_WIDTH  IF/ID PC+4.
- ifid_valid  out  1  IF/ID holds a real instruction.
- idex_ctrl  out  CTRL_WIDTH  ID/EX control register.
- stall_count  out  CNT_WIDTH  bubble cycles inserted.
- flush_count  out  CNT_WIDTH  branch flushes performed.
- hold_mismatch  out  1  sticky: pc_hold and ifid_hold differed in some cycle.

Behaviour:
- Reset (rst=1 at edge, overrides everything):
  - pc=RESET_PC; ifid_instr=0; ifid_pc_plus4=0; ifid_valid=0; idex_ctrl=0.
  - stall_count=0; flush_count=0; hold_mismatch=0.
- Reset mid-stall or mid-flush discards all pending state; the first post-reset cycle fetches RESET_PC.
- All outputs are registered; each control input takes effect at the next edge (1-cycle latency).
- pc_hold, ifid_hold and stall_or_control act independently, each on its own register.
- PC update, priority order:
  - pc_hold=1 -> pc unchanged.
  - else branch_taken=1 and ifid_hold=0 -> pc=branch_target with bits [1:0] forced to 0.
  - else pc=pc+4, wrapping modulo 2^PC_WIDTH (0xFFFFFFFC -> 0x00000000).
- IF/ID register, priority order:
  - ifid_hold=1 -> all IF/ID fields unchanged, including ifid_valid.
  - else branch_taken=1 -> ifid_instr=0, ifid_pc_plus4=0, ifid_valid=0 (flush); flush_count increments.
  - else ifid_instr=imem_instr, ifid_pc_plus4=pc+4, ifid_valid=1.
- ID/EX control register:
  - stall_or_control=1 or ifid_valid=0 -> idex_ctrl=0.
  - else idex_ctrl=id_ctrl_in.
  - A taken branch in ID still advances its own control into ID/EX.
- branch_taken while ifid_hold=1: ignored entirely (no redirect, no flush, no count). Stall wins; the branch re-resolves after the stall.
- stall_count increments on each edge with stall_or_control=1 and rst=0.
- Both counters saturate at all-ones and never wrap.
- hold_mismatch sets on any edge with pc_hold != ifid_hold; it is cleared only by rst.
- State summary, derived from inputs and ifid_valid:
  - EMPTY: ifid_valid=0, after reset or flush.
  - RUN: normal advance.
  - STALL: hold asserted; lasts for as many cycles as the hold is asserted.
  - EMPTY -> RUN on the first non-held, non-flush edge.

Test Plan:
1. Reset then 4 free-run cycles, imem_instr=0x8C0A0000, 0x014B6020, 0x00000000, 0x00000000 -> pc=0,4,8,12,16; ifid_valid 0 then 1; ifid_pc_plus4=4 after the first fetch; idex_ctrl=0 in the first cycle with ifid_valid=0.
2. Load-use stall: at pc=8 assert pc_hold=ifid_hold=stall_or_control=1 for one cycle -> pc stays 8, ifid_instr unchanged, idex_ctrl=0, stall_count=1; next cycle pc=12 and the held instruction advances with its id_ctrl_in.
3. Taken branch: branch_taken=1, branch_target=0x40 with no holds -> pc=0x40, ifid_valid=0, ifid_instr=0, flush_count=1; next cycle idex_ctrl=0 because the flushed slot was a bubble.
4. Branch during stall: branch_taken=1 with all holds=1 -> pc, IF/ID unchanged, flush_count unchanged, stall_count+1; hold_mismatch stays 0.
5. Mismatched holds and misaligned target: pc_hold=1, ifid_hold=0 for one cycle -> hold_mismatch=1 and stays 1 until rst; branch_target=0x43 -> pc=0x40.
6. Saturation and wrap: CNT_WIDTH=2 with 5 bubble cycles -> stall_count=3; pc=0xFFFFFFFC free-run -> pc=0; rst asserted mid-stall -> all outputs at reset values on the next edge.
